// File: rtl/seq_multiplier_cc.sv
// seq_multiplier_cc: multi-cycle shift-add multiplier with a start/busy/done
// handshake and zero/neg/overflow condition codes.
// Signed operands are reduced to magnitudes plus a result sign. The magnitude
// product is accumulated one multiplier bit per cycle. The sign is re-applied
// once at full precision before the result is truncated to P_WIDTH bits.
module seq_multiplier_cc #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int P_WIDTH   = A_WIDTH + B_WIDTH,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] product,
    output logic               zero,
    output logic               neg,
    output logic               overflow
);

    localparam int FULL_W = A_WIDTH + B_WIDTH;
    localparam int CNT_W  = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [A_WIDTH-1:0]  a_mag_q,    a_mag_d;
    logic [B_WIDTH-1:0]  b_shift_q,  b_shift_d;
    logic [FULL_W-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                sign_q,     sign_d;
    logic                mode_q,     mode_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [P_WIDTH-1:0]  product_q,  product_d;
    logic                zero_q,     zero_d;
    logic                neg_q,      neg_d;
    logic                overflow_q, overflow_d;

    // Operand conditioning: the effective mode and the unsigned magnitudes.
    // The magnitudes keep the operand width, so the most-negative value maps
    // onto its own bit pattern, which is the correct unsigned magnitude.
    logic               mode_eff;
    logic               a_is_neg;
    logic               b_is_neg;
    logic [A_WIDTH-1:0] a_abs;
    logic [B_WIDTH-1:0] b_abs;

    assign mode_eff = SIGNED_EN && signed_mode;
    assign a_is_neg = mode_eff && a[A_WIDTH-1];
    assign b_is_neg = mode_eff && b[B_WIDTH-1];
    assign a_abs    = a_is_neg ? (~a + A_WIDTH'(1)) : a;
    assign b_abs    = b_is_neg ? (~b + B_WIDTH'(1)) : b;

    // Partial product for the current iteration: the multiplicand magnitude
    // shifted to the weight of the multiplier bit being consumed.
    logic [FULL_W-1:0] addend;
    assign addend = {{B_WIDTH{1'b0}}, a_mag_q} << cnt_q;

    // Signed full-precision result and the two overflow interpretations.
    // When P_WIDTH equals the full width, an unsigned result cannot overflow.
    logic [FULL_W-1:0]        full;
    logic [FULL_W-P_WIDTH:0]  full_top;
    logic                     ovf_unsigned;
    logic                     ovf_signed;

    assign full       = sign_q ? (~acc_q + FULL_W'(1)) : acc_q;
    assign full_top   = full[FULL_W-1:P_WIDTH-1];
    assign ovf_signed = !((&full_top) || !(|full_top));

    generate
        if (P_WIDTH < FULL_W) begin : g_trunc
            assign ovf_unsigned = |full[FULL_W-1:P_WIDTH];
        end else begin : g_full
            assign ovf_unsigned = 1'b0;
        end
    endgenerate

    // Next-state and next-output logic for the IDLE/CALC/FIX/DONE sequence.
    always_comb begin
        state_d    = state_q;
        a_mag_d    = a_mag_q;
        b_shift_d  = b_shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        product_d  = product_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_mag_d   = a_abs;
                    b_shift_d = b_abs;
                    sign_d    = a_is_neg ^ b_is_neg;
                    mode_d    = mode_eff;
                    acc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (b_shift_q[0]) begin
                    acc_d = acc_q + addend;
                end
                b_shift_d = b_shift_q >> 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(B_WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                product_d  = full[P_WIDTH-1:0];
                zero_d     = (full[P_WIDTH-1:0] == '0);
                neg_d      = mode_q && full[P_WIDTH-1];
                overflow_d = mode_q ? ovf_signed : ovf_unsigned;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_mag_q    <= '0;
            b_shift_q  <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_mag_q    <= a_mag_d;
            b_shift_q  <= b_shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            product_q  <= product_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign zero     = zero_q;
    assign neg      = neg_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_multiplier_cc.sv
// Directed testbench for seq_multiplier_cc. It runs three instances in
// parallel from the same stimulus: the default configuration, an 8-bit
// truncated product, and one with signed mode disabled.
module tb_seq_multiplier_cc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic        busy, done, zero, neg, overflow;
    logic [15:0] product;
    logic        busy8, done8, zero8, neg8, overflow8;
    logic [7:0]  product8;
    logic        busy_u, done_u, zero_u, neg_u, overflow_u;
    logic [15:0] product_u;

    int n_cmp = 0;
    int n_err = 0;
    int cyc, bc;

    always #5 clk = ~clk;

    seq_multiplier_cc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product),
        .zero(zero), .neg(neg), .overflow(overflow)
    );

    seq_multiplier_cc #(.P_WIDTH(8)) dut_p8 (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy8), .done(done8), .product(product8),
        .zero(zero8), .neg(neg8), .overflow(overflow8)
    );

    seq_multiplier_cc #(.SIGNED_EN(1'b0)) dut_us (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy_u), .done(done_u), .product(product_u),
        .zero(zero_u), .neg(neg_u), .overflow(overflow_u)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One operation: start pulsed for one cycle, then wait (bounded) for done.
    // Returns the number of edges from the start edge to done, and busy cycles.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic sm,
                          output int cycles, output int busy_cnt);
        @(negedge clk);
        a = ta; b = tbv; signed_mode = sm; start = 1'b1;
        cycles = 0; busy_cnt = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (cycles == 1) start = 1'b0;
            if (busy) busy_cnt++;
        end while (!done && cycles < 40);
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int done_cnt, t1, t2;
        logic [15:0] first_prod;

        // Reset state
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_product", {16'b0, product}, 0);
        check("rst_flags", {29'b0, zero, neg, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 13*11 = 143
        run_op(8'd13, 8'd11, 1'b0, cyc, bc);
        check("u13x11_latency", cyc, 10);
        check("u13x11_busy_cycles", bc, 9);
        check("u13x11_product", {16'b0, product}, 32'h008F);
        check("u13x11_flags", {29'b0, zero, neg, overflow}, 0);

        // Signed -3*5 = -15; the unsigned-only instance sees 253*5 = 1265
        run_op(8'hFD, 8'h05, 1'b1, cyc, bc);
        check("s_m3x5_product", {16'b0, product}, 32'hFFF1);
        check("s_m3x5_flags", {29'b0, zero, neg, overflow}, 3'b010);
        check("nosigned_253x5_product", {16'b0, product_u}, 32'h04F1);
        check("nosigned_253x5_neg", {31'b0, neg_u}, 0);

        // Signed -128*-128 = 16384
        run_op(8'h80, 8'h80, 1'b1, cyc, bc);
        check("s_m128sq_product", {16'b0, product}, 32'h4000);
        check("s_m128sq_flags", {29'b0, zero, neg, overflow}, 0);

        // Zero operand keeps full latency
        run_op(8'd0, 8'd200, 1'b0, cyc, bc);
        check("zero_latency", cyc, 10);
        check("zero_product", {16'b0, product}, 0);
        check("zero_flags", {29'b0, zero, neg, overflow}, 3'b100);

        // Truncated 8-bit product
        run_op(8'd16, 8'd16, 1'b0, cyc, bc);
        check("p8_16x16_product", {24'b0, product8}, 0);
        check("p8_16x16_flags", {29'b0, zero8, neg8, overflow8}, 3'b101);
        check("p16_16x16_product", {16'b0, product}, 32'h0100);
        run_op(8'd15, 8'd17, 1'b0, cyc, bc);
        check("p8_15x17_product", {24'b0, product8}, 32'hFF);
        check("p8_15x17_flags", {29'b0, zero8, neg8, overflow8}, 0);
        run_op(8'hF0, 8'h08, 1'b1, cyc, bc);
        check("p8_m16x8_product", {24'b0, product8}, 32'h80);
        check("p8_m16x8_flags", {29'b0, zero8, neg8, overflow8}, 3'b010);

        // Second start pulse during CALC must be ignored
        @(negedge clk);
        a = 8'd6; b = 8'd7; signed_mode = 1'b0; start = 1'b1;
        done_cnt = 0; t1 = 0; first_prod = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 3) begin a = 8'd9; b = 8'd9; start = 1'b1; end
            if (i == 4) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin t1 = i; first_prod = product; end
            end
        end
        check("ignored_start_done_count", done_cnt, 1);
        check("ignored_start_latency", t1, 10);
        check("ignored_start_product", {16'b0, first_prod}, 32'h002A);

        // Start held high: back-to-back operations
        @(negedge clk);
        a = 8'd5; b = 8'd3; signed_mode = 1'b0; start = 1'b1;
        t1 = 0; t2 = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (t1 == 0) t1 = i;
                else if (t2 == 0) t2 = i;
            end
        end
        start = 1'b0;
        check("held_first_done", t1, 10);
        check("held_period", t2 - t1, 11);
        check("held_product", {16'b0, product}, 32'h000F);
        repeat (15) @(negedge clk);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a = 8'd13; b = 8'd11; signed_mode = 1'b0; start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_busy", {31'b0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_busy", {31'b0, busy}, 0);
        check("midreset_product", {16'b0, product}, 0);
        check("midreset_flags", {28'b0, done, zero, neg, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midreset_no_done", done_cnt, 0);

        run_op(8'd7, 8'd9, 1'b0, cyc, bc);
        check("post_reset_latency", cyc, 10);
        check("post_reset_product", {16'b0, product}, 32'h003F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
